phy_tx_word_pacer: RTL and testbench
====================================

Name: phy_tx_word_pacer

Overview:
Upstream stage of the PHY transmit path. Accepts 32-bit words from the link layer over a valid/ready handshake and buffers them in a small FIFO. Presents them to the PHY's valid_in/Data_in inputs at the fixed word-slot rate: each word is held for WORD_CYCLES clk_32f cycles. Emits idle slots (valid low, data zero) whenever no word is queued.

Parameters:
DATA_WIDTH, 32, word width; must match the PHY data input.
DEPTH, 4, FIFO depth in words; power of two, >= 2.
WORD_CYCLES, 16, clk_32f cycles per word slot; >= 2.

Ports:
clk_32f  input  1  single clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
wr_valid  input  1  producer has a word on wr_data.
wr_data  input  DATA_WIDTH  word from producer.
wr_ready  output  1  FIFO can accept; a transfer occurs on an edge where wr_valid && wr_ready.
valid_out  output  1  drives PHY valid_in; constant for a whole slot.
Data_out  output  DATA_WIDTH  drives PHY Data_in; constant for a whole slot.
slot_start  output  1  high during the first cycle of each slot (slot_cnt == 0).
fifo_count  output  clog2(DEPTH)+1  words currently queued.

Behaviour:
- Clock and reset: one clock (clk_32f). Reset is synchronous and active-high.
- Reset values:
  - valid_out = 0, Data_out = 0, fifo_count = 0.
  - slot_cnt = 0; FIFO pointers = 0.
  - wr_ready = 0 while reset is high; 1 on the first cycle after release.
- Reset mid-operation: queued words are discarded and never appear on Data_out. valid_out drops at the reset edge.
- wr_ready is combinational: !full && !reset, where full means fifo_count == DEPTH.
- Slot counter:
  - slot_cnt counts 0..WORD_CYCLES-1, free-running from reset release.
  - On an edge where slot_cnt == WORD_CYCLES-1 (the boundary edge), slot_cnt wraps to 0.
- Boundary edge actions:
  - If fifo_count (pre-edge) > 0: pop the head; Data_out <= head; valid_out <= 1.
  - Otherwise: valid_out <= 0; Data_out <= 0 (idle slot).
- Outputs change only on boundary edges or reset. The first boundary edge is the WORD_CYCLES-th rising edge after reset release.
- Push/pop interaction:
  - A word pushed on a boundary edge is not eligible for that edge's pop.
  - Minimum latency from acceptance into an empty FIFO to valid_out high: 1..WORD_CYCLES cycles, depending on slot phase.
- Count updates:
  - Push and pop on the same edge: fifo_count unchanged; read and write pointers both advance.
  - Push only: +1. Pop only: -1.
- Full condition: no push is possible while full. After a pop from full, wr_ready rises in the next cycle.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Order is strictly FIFO.
- Back-to-back queued words give contiguous valid_out = 1 across slots, with Data_out changing only at boundaries.

Optional Feature:
PACER_STATS_EN.
- Defined: adds outputs sent_count[15:0] and idle_count[15:0].
  - sent_count increments on each boundary edge that loads a word.
  - idle_count increments on each boundary edge that loads idle.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package phy_pkg:
  - PHY_DATA_W = 32.
  - PHY_WORD_CYCLES = 16.
  - PHY_IDLE_DATA = 0.
  - Helper function for counter width (clog2).
- One sub-module, phy_sync_fifo: storage, read/write pointers, count, full/empty.
- phy_tx_word_pacer holds the slot counter, output registers and optional statistics.

Test Plan:
- Reset: hold reset 3 cycles, then release → valid_out=0, Data_out=0, fifo_count=0, wr_ready=0 during reset and 1 one cycle after release; slot_start high on the first cycle after release.
- Single word: push 0xFFFFFFFF at cycle 2 after release → valid_out=1, Data_out=0xFFFFFFFF for exactly 16 cycles starting at the 16th edge, then valid_out=0, Data_out=0.
- Burst to full: push 0xFFFFFFFF, 0xEEEEEEEE, 0xDDDDDDDD, 0xCCCCCCCC back-to-back:
  - fifo_count reaches 4 and wr_ready=0.
  - A held 0x00000003 is accepted only after the first pop.
  - Five consecutive valid slots appear in order, with no idle gap.
- Simultaneous push/pop: fifo_count=1 and a push on the boundary edge → count stays 1; the pushed 0xAAAAAAAA appears one slot after the popped word.
- Mid-slot reset: words 0x00000007 and 0x00000008 queued, reset asserted at slot_cnt=5 → valid_out=0, fifo_count=0 on the next edge; neither word is ever output.
- PACER_STATS_EN: push 3 words, then run 2 empty slots → sent_count=3, idle_count=2; reset → both 0.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared constants and helpers for the PHY transmit path.
// Holds the default word width, slot length, idle data pattern and a counter-width helper.
package phy_pkg;

    localparam int PHY_DATA_W      = 32;
    localparam int PHY_WORD_CYCLES = 16;

    localparam logic [PHY_DATA_W-1:0] PHY_IDLE_DATA = '0;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int phy_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phy_sync_fifo.sv
// Synchronous word FIFO for the PHY transmit pacer.
// Ports: clk_32f, reset (sync, active-high), push/push_data, pop/head, count, full, empty.
module phy_sync_fifo
    import phy_pkg::*;
#(
    parameter int DATA_WIDTH = PHY_DATA_W,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_32f,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = phy_cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_32f) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/phy_tx_word_pacer.sv
// Paces queued link-layer words onto the PHY input, one word per WORD_CYCLES-cycle slot.
// Ports: clk_32f, reset (sync, active-high), wr_valid/wr_data/wr_ready (producer side),
//        valid_out/Data_out (PHY side), slot_start, fifo_count.
// Optional: define PACER_STATS_EN to add saturating sent_count/idle_count outputs.
module phy_tx_word_pacer
    import phy_pkg::*;
#(
    parameter int DATA_WIDTH  = PHY_DATA_W,
    parameter int DEPTH       = 4,
    parameter int WORD_CYCLES = PHY_WORD_CYCLES
) (
    input  logic                    clk_32f,
    input  logic                    reset,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    output logic                    valid_out,
    output logic [DATA_WIDTH-1:0]   Data_out,
    output logic                    slot_start,
    output logic [$clog2(DEPTH):0]  fifo_count
`ifdef PACER_STATS_EN
    ,
    output logic [15:0]             sent_count,
    output logic [15:0]             idle_count
`endif
);

    localparam int SW = phy_cnt_w(WORD_CYCLES);
    localparam logic [SW-1:0] LAST_SLOT = SW'(WORD_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] IDLE_WORD = DATA_WIDTH'(PHY_IDLE_DATA);

    logic [SW-1:0]         slot_cnt;
    logic                  boundary;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] head;

    assign boundary   = (slot_cnt == LAST_SLOT);
    assign slot_start = (slot_cnt == '0);
    assign wr_ready   = !full && !reset;
    assign push       = wr_valid && wr_ready;
    // Pop decision uses the pre-edge occupancy, so a word pushed on
    // the boundary edge waits for the following slot.
    assign pop        = boundary && !empty;

    phy_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .push       (push),
        .push_data  (wr_data),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            slot_cnt  <= '0;
            valid_out <= 1'b0;
            Data_out  <= IDLE_WORD;
        end else begin
            slot_cnt <= boundary ? '0 : slot_cnt + 1'b1;
            if (boundary) begin
                valid_out <= !empty;
                Data_out  <= empty ? IDLE_WORD : head;
            end
        end
    end

`ifdef PACER_STATS_EN
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sent_count <= '0;
            idle_count <= '0;
        end else if (boundary) begin
            if (!empty && sent_count != 16'hFFFF)
                sent_count <= sent_count + 1'b1;
            if (empty && idle_count != 16'hFFFF)
                idle_count <= idle_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_tx_word_pacer.sv
// Scoreboard bench for phy_tx_word_pacer.
// Stimulus queues expected words; a monitor checks every cycle's slot outputs.
module tb_phy_tx_word_pacer;
    import phy_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int WC    = 16;

    logic                  clk_32f = 1'b0;
    logic                  reset = 1'b1;
    logic                  wr_valid = 1'b0;
    logic [DW-1:0]         wr_data = '0;
    logic                  wr_ready;
    logic                  valid_out;
    logic [DW-1:0]         Data_out;
    logic                  slot_start;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef PACER_STATS_EN
    logic [15:0]           sent_count;
    logic [15:0]           idle_count;
`endif

    phy_tx_word_pacer #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .WORD_CYCLES (WC)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .valid_out  (valid_out),
        .Data_out   (Data_out),
        .slot_start (slot_start),
        .fifo_count (fifo_count)
`ifdef PACER_STATS_EN
        ,
        .sent_count (sent_count),
        .idle_count (idle_count)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            edge_no = 0;
    int            ph = 0;
    logic          exp_v = 1'b0;
    logic [DW-1:0] exp_d = '0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Slot model: reset zeroes the phase; on each boundary edge the oldest
    // word accepted strictly before that edge is shown, otherwise idle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_32f);
            edge_no++;
            if (reset) begin
                ph    = 0;
                exp_v = 1'b0;
                exp_d = '0;
            end else if (ph == WC - 1) begin
                ph = 0;
                if (sb.size() > 0 && sb[0].acc < edge_no) begin
                    e     = sb.pop_front();
                    exp_v = 1'b1;
                    exp_d = e.data;
                end else begin
                    exp_v = 1'b0;
                    exp_d = '0;
                end
            end else begin
                ph++;
            end
            @(negedge clk_32f);
            check("valid_out", 32'(valid_out), 32'(exp_v));
            check("Data_out", Data_out, exp_d);
            check("slot_start", 32'(slot_start), 32'(ph == 0));
        end
    end

    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        tick();
        while (ph != p && n < 4 * WC) begin
            tick();
            n++;
        end
        if (ph != p) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: phase %0d never reached", p);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        bit ok;
        ok       = 1'b0;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_32f);
            ok = wr_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: word %h never accepted", d);
            wr_valid = 1'b0;
            tick();
        end else begin
            tick();
            sb.push_back('{data: d, acc: edge_no});
            wr_valid = 1'b0;
        end
    endtask

    initial begin : stim
        bit held;

        // Reset held for three edges, then released.
        repeat (3) tick();
        @(negedge clk_32f);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_Data_out", Data_out, 32'd0);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        @(negedge clk_32f);
        check("rel_wr_ready", 32'(wr_ready), 32'd1);
        check("rel_slot_start", 32'(slot_start), 32'd1);
        check("rel_fifo_count", 32'(fifo_count), 32'd0);

        // Single word, shown for one full slot.
        tick();
        push_word(32'hFFFF_FFFF);
        @(negedge clk_32f);
        check("single_count", 32'(fifo_count), 32'd1);
        repeat (40) tick();

        // Burst to full; a fifth word waits for the first pop.
        wait_phase(0);
        push_word(32'hFFFF_FFFF);
        push_word(32'hEEEE_EEEE);
        push_word(32'hDDDD_DDDD);
        push_word(32'hCCCC_CCCC);
        @(negedge clk_32f);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 32'h0000_0003;
        held     = 1'b0;
        for (int i = 0; i < 3 * WC && !held; i++) begin
            @(negedge clk_32f);
            if (ph == 0) held = 1'b1;
            else check("held_wr_ready", 32'(wr_ready), 32'd0);
        end
        check("pop_wr_ready", 32'(wr_ready), 32'd1);
        check("pop_count", 32'(fifo_count), 32'd3);
        tick();
        sb.push_back('{data: 32'h0000_0003, acc: edge_no});
        wr_valid = 1'b0;
        @(negedge clk_32f);
        check("refill_count", 32'(fifo_count), 32'd4);
        repeat (90) tick();
        @(negedge clk_32f);
        check("drain_count", 32'(fifo_count), 32'd0);

        // Push on the boundary edge while one word is queued.
        wait_phase(0);
        push_word(32'h5555_5555);
        wait_phase(WC - 1);
        push_word(32'hAAAA_AAAA);
        @(negedge clk_32f);
        check("pushpop_count", 32'(fifo_count), 32'd1);
        repeat (40) tick();

        // Reset in mid-slot discards queued words.
        wait_phase(0);
        push_word(32'h0000_0007);
        push_word(32'h0000_0008);
        wait_phase(5);
        reset = 1'b1;
        sb.delete();
        @(negedge clk_32f);
        check("midrst_pre_count", 32'(fifo_count), 32'd2);
        check("midrst_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk_32f);
        @(negedge clk_32f);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_valid", 32'(valid_out), 32'd0);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        repeat (40) tick();

        // Three words then two idle slots.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        push_word(32'h3333_3333);
        repeat (5) wait_phase(0);
        @(negedge clk_32f);
        check("stats_fifo_count", 32'(fifo_count), 32'd0);
`ifdef PACER_STATS_EN
        check("sent_count", 32'(sent_count), 32'd3);
        check("idle_count", 32'(idle_count), 32'd2);
        @(posedge clk_32f);
        #1;
        reset = 1'b1;
        @(posedge clk_32f);
        @(negedge clk_32f);
        check("rst_sent_count", 32'(sent_count), 32'd0);
        check("rst_idle_count", 32'(idle_count), 32'd0);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
`endif
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
